// File: rtl/bcd_display_driver_if.sv
// Connection bundle for bcd_display_driver.
//   done      : multiplier completion flag (level), only its rising edge matters
//   PP        : 8-bit multiplier product, sampled on the done rising edge
//   busy      : conversion in progress
//   bcd       : last converted result {hundreds, tens, units}
//   bcd_valid : sticky, set by the first completed conversion
//   seg       : segment drive {g,f,e,d,c,b,a}, active-low
//   an        : digit enables, active-low (an[0] units .. an[2] hundreds, an[3] unused)
// master = multiplier / display side, slave = the driver itself.
interface bcd_display_driver_if;
  logic        done;
  logic [7:0]  PP;
  logic        busy;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (
    output done,
    output PP,
    input  busy,
    input  bcd,
    input  bcd_valid,
    input  seg,
    input  an
  );

  modport slave (
    input  done,
    input  PP,
    output busy,
    output bcd,
    output bcd_valid,
    output seg,
    output an
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Captures an 8-bit product on the rising edge of done, converts it to three BCD digits
// with a sequential double-dabble engine (one iteration per cycle), holds the result and
// scans it onto a common-anode 4-digit 7-segment display with leading-zero blanking.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-low reset
//   bus : bcd_display_driver_if slave modport (done, PP in; busy, bcd, bcd_valid, seg, an out)
// SCAN_DIV : clock cycles per displayed digit slot (>= 2).
module bcd_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                  clk,
  input logic                  rst,
  bcd_display_driver_if.slave  bus
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

  state_e      state_q, state_d;
  logic        done_q;
  logic        start;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] scr_q, scr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        valid_q, valid_d;
  logic [11:0] scr_adj;

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  // done_q tracks done every cycle, so a held-high done never retriggers.
  assign start = bus.done & ~done_q;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State register plus all datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
    end else begin
      state_q <= state_d;
      done_q  <= bus.done;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StConv;
      StConv:  if (cnt_q == 3'd7) state_d = StLoad;
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Add-3 correction on each scratch nibble before the shift.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < 3; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Output / datapath logic driven by the current state.
  always_comb begin
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d = bus.PP;
          scr_d = '0;
          cnt_d = '0;
        end
      end
      StConv: begin
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
        cnt_d          = cnt_q + 3'd1;
      end
      StLoad: begin
        bcd_d   = scr_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Scan divider and digit index: 0 -> 1 -> 2 -> 0, advancing on each divider wrap.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DivMax) begin
      div_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Digit select with leading-zero blanking; registered, so one cycle behind idx/bcd.
  always_comb begin
    logic [3:0] h, t, u;
    h     = bcd_q[11:8];
    t     = bcd_q[7:4];
    u     = bcd_q[3:0];
    seg_d = 7'b1111111;
    an_d  = 4'b1111;
    if (valid_q) begin
      case (idx_q)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = seg_code(u);
        end
        2'd1: begin
          if (h != 4'd0 || t != 4'd0) begin
            an_d  = 4'b1101;
            seg_d = seg_code(t);
          end
        end
        2'd2: begin
          if (h != 4'd0) begin
            an_d  = 4'b1011;
            seg_d = seg_code(h);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = valid_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule
